multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//   Multicycle control FSM for the RV32I core subset (lw, sw, R-type, I-type ALU, beq, jal).
//   Sequences one shared ALU, one unified instruction/data memory and the register file over
//   several cycles per instruction, instead of decoding everything in one cycle.
//   Sits between the instruction register / ALU flags and the datapath mux selects and write strobes.
// PARAMETERS
//   TRAP_ON_ILLEGAL  1  1: unknown opcode -> ERROR state (held until rst); 0: unknown opcode -> FETCH (treated as nop)
// PORTS
//   clk         in   1  system clock; all state updates on rising edge
//   rst         in   1  synchronous, active-high reset
//   op          in   7  opcode from instruction register
//   funct3      in   3  instr[14:12]
//   funct7      in   1  instr[30]
//   Zero        in   1  ALU result == 0
//   MemReady    in   1  memory access completes this cycle
//   PCWrite     out  1  PC register enable
//   AdrSrc      out  1  memory address: 0 = PC, 1 = ALUOut
//   MemWrite    out  1  memory write strobe
//   IRWrite     out  1  instruction register / OldPC enable
//   RegWrite    out  1  register file write strobe
//   ResultSrc   out  2  00 ALUOut, 01 mem data, 10 ALU result
//   ALUSrcA     out  2  00 PC, 01 OldPC, 10 rs1
//   ALUSrcB     out  2  00 rs2, 01 imm, 10 const 4
//   ImmSrc      out  2  00 I, 01 S, 10 B, 11 J (combinational from op; 00 for any other op)
//   ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//   InstrDone   out  1  1-cycle pulse in the last cycle of each instruction
//   Trap        out  1  high while in ERROR
//   State       out  4  current state encoding, for debug
// BEHAVIOUR
//   - States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5,
//     EXECR 6, EXECI 7, ALUWB 8, JAL 9, BEQ 10, ERROR 11.
//   - Reset: a clock edge with rst=1 sets State=FETCH. While rst=1, PCWrite, MemWrite, IRWrite,
//     RegWrite, InstrDone and Trap are forced 0. rst wins over any transition, including mid-access.
//   - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10.
//     IRWrite=PCWrite=MemReady. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
//   - DECODE: ALUSrcA=01, ALUSrcB=01, add (computes branch/jump target). Next state by op:
//     0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1101111 -> JAL,
//     1100011 -> BEQ, any other op -> ERROR or FETCH (per TRAP_ON_ILLEGAL).
//   - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next: lw -> MEMREAD, sw -> MEMWRITE.
//   - MEMREAD: AdrSrc=1, ResultSrc=00. Holds until MemReady=1, then MEMWB.
//   - MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1 -> FETCH.
//   - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 for every cycle in this state.
//     Holds until MemReady=1, then FETCH with InstrDone=1 in that cycle.
//   - EXECR: ALUSrcA=10, ALUSrcB=00, ALU decode -> ALUWB.
//   - EXECI: ALUSrcA=10, ALUSrcB=01, ALU decode -> ALUWB.
//   - ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1 -> FETCH.
//   - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB (rd = PC+4).
//   - BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero, InstrDone=1 -> FETCH.
//   - ERROR: all strobes 0, Trap=1. Leaves only on rst.
//   - ALU decode (EXECR/EXECI), by funct3:
//     000 -> sub if (op==0110011 && funct7) else add; 010 -> slt; 110 -> or; 111 -> and;
//     any other funct3 -> add.
//   - Write strobes not listed for a state are 0. Unlisted selects are 00.
//   - Latency (MemReady=1 throughout): lw 5 cycles, sw 4, R/I 4, jal 4, beq 3.
//     Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
//   - At most one of RegWrite/MemWrite is high in any cycle. IRWrite is high only in FETCH.
// TESTING
//   1. rst=1 for 2 cycles with MemReady=1 -> State=0; PCWrite, IRWrite, RegWrite, MemWrite all 0 during rst.
//   2. lw (op=0000011), MemReady=1 -> State sequence 0,1,2,3,4,0; RegWrite=1 and ResultSrc=01
//      only in state 4; InstrDone pulses once.
//   3. sw (op=0100011), MemReady=0 for first 2 MEMWRITE cycles -> MemWrite=1 for exactly 3 cycles,
//      AdrSrc=1 throughout, RegWrite never 1.
//   4. beq with Zero=1 -> PCWrite=1, ALUControl=001 in state 10; repeat with Zero=0 -> PCWrite=0 in state 10.
//   5. R-type funct3=000 funct7=1 -> ALUControl=001 in EXECR; addi (op=0010011) funct3=000 funct7=1
//      -> ALUControl=000; funct3=111 -> 010.
//   6. op=0000000 with TRAP_ON_ILLEGAL=1 -> DECODE->ERROR, Trap=1 held; rst -> FETCH.
//      rst asserted while in MEMREAD with MemReady=0 -> State=0 next cycle, no RegWrite.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for an RV32I subset (lw, sw, R-type, I-type ALU, beq, jal).
// Drives the datapath mux selects and write strobes for one shared ALU, a
// unified memory and the register file, one instruction over several cycles.
module multicycle_ctrl #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       InstrDone,
    output logic       Trap,
    output logic [3:0] State
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ERROR    = 4'd11
    } state_t;

    state_t state, state_nxt;
    logic [2:0] alu_dec;

    // State register; reset overrides any pending transition.
    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    assign State = state;

    // Immediate format straight from the opcode, independent of state.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // ALU operation for the execute states; sub only for R-type with funct7 set.
    always_comb begin
        alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec = (op == OP_R && funct7) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    // Next-state and datapath controls; strobes are masked while rst is high.
    always_comb begin
        state_nxt  = state;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        InstrDone  = 1'b0;
        Trap       = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECR;
                    OP_I:         state_nxt = S_EXECI;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_BEQ:       state_nxt = S_BEQ;
                    default:      state_nxt = TRAP_ON_ILLEGAL ? S_ERROR : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                state_nxt = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = MemReady;
                if (MemReady) state_nxt = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec;
                state_nxt  = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
                state_nxt  = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                PCWrite   = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = Zero;
                InstrDone  = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_ERROR: begin
                Trap = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
        if (rst) begin
            PCWrite   = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            InstrDone = 1'b0;
            Trap      = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: one record per clock cycle holding
// the inputs and every expected output, plus hand sequences for reset cases.
module tb_multicycle_ctrl;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] ILL = 7'b0000000;

    typedef struct packed {
        logic [3:0] st;
        logic [4:0] strb;   // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite}
        logic [1:0] rs;
        logic [1:0] asa;
        logic [1:0] asb;
        logic [1:0] imm;
        logic [2:0] alu;
        logic       done;
        logic       trap;
    } exp_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic       mr;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7, Zero, MemReady;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, Trap;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    logic       d0_PCWrite, d0_AdrSrc, d0_MemWrite, d0_IRWrite, d0_RegWrite, d0_InstrDone, d0_Trap;
    logic [1:0] d0_ResultSrc, d0_ALUSrcA, d0_ALUSrcB, d0_ImmSrc;
    logic [2:0] d0_ALUControl;
    logic [3:0] d0_State;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .InstrDone(InstrDone), .Trap(Trap),
        .State(State)
    );

    multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .MemReady(MemReady),
        .PCWrite(d0_PCWrite), .AdrSrc(d0_AdrSrc), .MemWrite(d0_MemWrite), .IRWrite(d0_IRWrite),
        .RegWrite(d0_RegWrite), .ResultSrc(d0_ResultSrc), .ALUSrcA(d0_ALUSrcA), .ALUSrcB(d0_ALUSrcB),
        .ImmSrc(d0_ImmSrc), .ALUControl(d0_ALUControl), .InstrDone(d0_InstrDone), .Trap(d0_Trap),
        .State(d0_State)
    );

    function automatic vec_t v(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                               input logic z, input logic mr, input logic [3:0] st,
                               input logic [4:0] strb, input logic [1:0] rs, input logic [1:0] asa,
                               input logic [1:0] asb, input logic [1:0] imm, input logic [2:0] alu,
                               input logic done, input logic trap);
        vec_t r;
        r.op = o; r.f3 = f3; r.f7 = f7; r.z = z; r.mr = mr;
        r.e = '{st: st, strb: strb, rs: rs, asa: asa, asb: asb, imm: imm, alu: alu,
                done: done, trap: trap};
        return r;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a = '{st: State, strb: {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite}, rs: ResultSrc,
              asa: ALUSrcA, asb: ALUSrcB, imm: ImmSrc, alu: ALUControl, done: InstrDone,
              trap: Trap};
        return a;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic r, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic z, input logic mr);
        rst = r; op = o; funct3 = f3; funct7 = f7; Zero = z; MemReady = mr;
        #1;
    endtask

    // Fetch+decode rows shared by most instructions.
    task automatic fd(inout vec_t t[$], input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic z, input logic [1:0] imm);
        t.push_back(v(o, f3, f7, z, 1, 0, 5'b10010, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0));
        t.push_back(v(o, f3, f7, z, 1, 1, 5'b00000, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0, 0));
    endtask

    initial begin
        vec_t tbl[$];
        bit   seen_err;
        int   rw_seen;

        // lw, no stalls: 0,1,2,3,4
        fd(tbl, LW, 3'b010, 0, 0, 2'b00);
        tbl.push_back(v(LW, 3'b010, 0, 0, 1, 2,  5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0));
        tbl.push_back(v(LW, 3'b010, 0, 0, 1, 3,  5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        tbl.push_back(v(LW, 3'b010, 0, 0, 1, 4,  5'b00001, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
        // sw, MemReady low for the first two MEMWRITE cycles
        fd(tbl, SW, 3'b010, 0, 0, 2'b01);
        tbl.push_back(v(SW, 3'b010, 0, 0, 1, 2,  5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0, 0));
        tbl.push_back(v(SW, 3'b010, 0, 0, 0, 5,  5'b01100, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0));
        tbl.push_back(v(SW, 3'b010, 0, 0, 0, 5,  5'b01100, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0));
        tbl.push_back(v(SW, 3'b010, 0, 0, 1, 5,  5'b01100, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1, 0));
        // beq taken
        fd(tbl, BEQ, 3'b000, 0, 1, 2'b10);
        tbl.push_back(v(BEQ, 3'b000, 0, 1, 1, 10, 5'b10000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1, 0));
        // beq not taken, with one fetch stall cycle first
        tbl.push_back(v(BEQ, 3'b000, 0, 0, 0, 0,  5'b00000, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0, 0));
        fd(tbl, BEQ, 3'b000, 0, 0, 2'b10);
        tbl.push_back(v(BEQ, 3'b000, 0, 0, 1, 10, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1, 0));
        // R-type sub
        fd(tbl, RT, 3'b000, 1, 0, 2'b00);
        tbl.push_back(v(RT, 3'b000, 1, 0, 1, 6,  5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0, 0));
        tbl.push_back(v(RT, 3'b000, 1, 0, 1, 8,  5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
        // addi with funct7 bit set stays add
        fd(tbl, IT, 3'b000, 1, 0, 2'b00);
        tbl.push_back(v(IT, 3'b000, 1, 0, 1, 7,  5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0));
        tbl.push_back(v(IT, 3'b000, 1, 0, 1, 8,  5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
        // andi
        fd(tbl, IT, 3'b111, 0, 0, 2'b00);
        tbl.push_back(v(IT, 3'b111, 0, 0, 1, 7,  5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b010, 0, 0));
        tbl.push_back(v(IT, 3'b111, 0, 0, 1, 8,  5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
        // slt
        fd(tbl, RT, 3'b010, 0, 0, 2'b00);
        tbl.push_back(v(RT, 3'b010, 0, 0, 1, 6,  5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b101, 0, 0));
        tbl.push_back(v(RT, 3'b010, 0, 0, 1, 8,  5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
        // or, then an unlisted funct3 (001) falls back to add
        fd(tbl, RT, 3'b110, 0, 0, 2'b00);
        tbl.push_back(v(RT, 3'b110, 0, 0, 1, 6,  5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b011, 0, 0));
        tbl.push_back(v(RT, 3'b110, 0, 0, 1, 8,  5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
        fd(tbl, RT, 3'b001, 1, 0, 2'b00);
        tbl.push_back(v(RT, 3'b001, 1, 0, 1, 6,  5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 0, 0));
        tbl.push_back(v(RT, 3'b001, 1, 0, 1, 8,  5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
        // jal
        fd(tbl, JAL, 3'b000, 0, 0, 2'b11);
        tbl.push_back(v(JAL, 3'b000, 0, 0, 1, 9, 5'b10000, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0, 0));
        tbl.push_back(v(JAL, 3'b000, 0, 0, 1, 8, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1, 0));
        // illegal opcode traps and holds
        fd(tbl, ILL, 3'b000, 0, 0, 2'b00);
        tbl.push_back(v(ILL, 3'b000, 0, 0, 1, 11, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1));
        tbl.push_back(v(ILL, 3'b000, 0, 0, 1, 11, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1));
        tbl.push_back(v(LW,  3'b000, 0, 0, 1, 11, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1));

        // reset: two cycles with MemReady=1, strobes held low
        for (int c = 0; c < 2; c++) begin
            drive(1, LW, 3'b000, 0, 0, 1);
            check($sformatf("rst_strobes_c%0d", c),
                  {26'd0, PCWrite, IRWrite, RegWrite, MemWrite, InstrDone, Trap}, 32'd0);
            if (c == 1) check("rst_state", {28'd0, State}, 32'd0);
            @(negedge clk);
        end

        seen_err = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(0, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].mr);
            check($sformatf("vec%0d", i), {10'd0, actual()}, {10'd0, tbl[i].e});
            if (tbl[i].e.st == 4'd11 && !seen_err) begin
                seen_err = 1;
                check("nontrap_illegal_state", {27'd0, d0_Trap, d0_State}, 32'd0);
            end
            @(negedge clk);
        end

        // reset out of ERROR
        drive(1, LW, 3'b010, 0, 0, 1);
        check("rst_from_err_trap", {31'd0, Trap}, 32'd0);
        @(negedge clk);
        drive(0, LW, 3'b010, 0, 0, 1);
        check("err_to_fetch", {28'd0, State}, 32'd0);
        @(negedge clk);                     // -> DECODE
        drive(0, LW, 3'b010, 0, 0, 1);
        @(negedge clk);                     // -> MEMADR
        drive(0, LW, 3'b010, 0, 0, 0);
        @(negedge clk);                     // -> MEMREAD
        rw_seen = 0;
        for (int c = 0; c < 2; c++) begin
            drive(0, LW, 3'b010, 0, 0, 0);
            check($sformatf("memread_hold_c%0d", c), {28'd0, State}, 32'd3);
            rw_seen += RegWrite;
            @(negedge clk);
        end
        // rst mid-access with MemReady still low
        drive(1, LW, 3'b010, 0, 0, 0);
        rw_seen += RegWrite;
        @(negedge clk);
        drive(0, LW, 3'b010, 0, 0, 0);
        check("rst_midread_state", {28'd0, State}, 32'd0);
        rw_seen += RegWrite;
        check("rst_midread_no_regwrite", rw_seen, 0);
        check("fetch_stall_irwrite", {31'd0, IRWrite}, 32'd0);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
